// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: byte-addressed little-endian data memory with a valid/ready request channel and a fixed-latency response pipeline
//   clk_i         clock; all state updates on posedge
//   rst_ni        synchronous active-low reset (clears the pipeline, not the memory)
//   req_valid_i   request present
//   req_ready_o   request can be accepted this cycle
//   req_we_i      1 = store, 0 = load
//   req_funct3_i  RV32 funct3 access size/sign
//   req_addr_i    byte address
//   req_wdata_i   store data, low bytes used for SB/SH
//   rsp_valid_o   response present
//   rsp_ready_i   consumer takes the response
//   rsp_rdata_o   load result extended per funct3; 0 for stores and faults
//   rsp_fault_o   access rejected (misaligned, out of range or illegal funct3)
module data_mem_ctrl #(
   parameter int DEPTH_BYTES = 2048,
   parameter int RD_LAT      = 1
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        req_valid_i,
   output logic        req_ready_o,
   input  logic        req_we_i,
   input  logic [2:0]  req_funct3_i,
   input  logic [31:0] req_addr_i,
   input  logic [31:0] req_wdata_i,
   output logic        rsp_valid_o,
   input  logic        rsp_ready_i,
   output logic [31:0] rsp_rdata_o,
   output logic        rsp_fault_o
);
   localparam int AW = $clog2(DEPTH_BYTES);
   logic [7:0]        mem_q [DEPTH_BYTES];
   logic [RD_LAT-1:0] vld_q;
   logic [RD_LAT-1:0] fault_q;
   logic [31:0]       rdata_q [RD_LAT];
   logic              stall, accept, ill_f3, misaligned, out_of_range, fault;
   logic              fault_d;
   logic [AW-1:0]     a0, a1, a2, a3;
   logic [31:0]       word, rd_ext, rdata_d;
   // The whole pipeline freezes while the output stage is held, so responses stay stable and ordered
   assign stall       = vld_q[RD_LAT-1] & ~rsp_ready_i;
   assign req_ready_o = rst_ni & ~stall;
   assign accept      = req_valid_i & req_ready_o;
   // Codes 011, 11x are never legal; stores only have 000/001/010
   assign ill_f3       = (req_funct3_i == 3'b011) | (req_funct3_i[2:1] == 2'b11) | (req_we_i & req_funct3_i[2]);
   assign misaligned   = ((req_funct3_i[1:0] == 2'b01) & req_addr_i[0]) |
                         ((req_funct3_i[1:0] == 2'b10) & (|req_addr_i[1:0]));
   // High bits are checked rather than masked so addresses never alias into the array
   assign out_of_range = |req_addr_i[31:AW];
   assign fault        = ill_f3 | misaligned | out_of_range;
   assign a0 = req_addr_i[AW-1:0];
   assign a1 = a0 + AW'(1);
   assign a2 = a0 + AW'(2);
   assign a3 = a0 + AW'(3);
   assign word   = {mem_q[a3], mem_q[a2], mem_q[a1], mem_q[a0]};
   assign rd_ext = (req_funct3_i[1:0] == 2'b00) ? {{24{~req_funct3_i[2] & word[7]}}, word[7:0]}
                 : (req_funct3_i[1:0] == 2'b01) ? {{16{~req_funct3_i[2] & word[15]}}, word[15:0]}
                 : word;
   // Idle slots carry zeros so the output stage reads 0 whenever nothing is valid
   assign rdata_d = (accept & ~fault & ~req_we_i) ? rd_ext : 32'h0;
   assign fault_d = accept & fault;
   always_ff @(posedge clk_i) begin
      if (accept & req_we_i & ~fault) begin
         mem_q[a0] <= req_wdata_i[7:0];
         if (req_funct3_i[1:0] != 2'b00) mem_q[a1] <= req_wdata_i[15:8];
         if (req_funct3_i[1:0] == 2'b10) begin
            mem_q[a2] <= req_wdata_i[23:16];
            mem_q[a3] <= req_wdata_i[31:24];
         end
      end
   end
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         vld_q   <= '0;
         fault_q <= '0;
         for (int i = 0; i < RD_LAT; i++) rdata_q[i] <= '0;
      end else if (!stall) begin
         for (int i = RD_LAT - 1; i > 0; i--) begin
            vld_q[i]   <= vld_q[i-1];
            fault_q[i] <= fault_q[i-1];
            rdata_q[i] <= rdata_q[i-1];
         end
         vld_q[0]   <= accept;
         fault_q[0] <= fault_d;
         rdata_q[0] <= rdata_d;
      end
   end
   assign rsp_valid_o = vld_q[RD_LAT-1];
   assign rsp_fault_o = fault_q[RD_LAT-1];
   assign rsp_rdata_o = rdata_q[RD_LAT-1];
endmodule
